// File: rtl/micro_op_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : micro_op_queue_pkg
// Description : Shared decoder/back-end types for the micro-op queue.
//               micro_op_t is the cracked micro-op carried between the
//               decoder and register-read stage; mop_queue_lane_t is the
//               lane-array alias; MOP_Q_* are the default queue geometry so
//               both sides agree on lane widths.
// Revision    : 1.0 - initial release
// ============================================================================
package micro_op_queue_pkg;

  typedef enum logic [3:0] {
    MOP_NOP = 4'd0,
    MOP_ADD = 4'd1,
    MOP_SUB = 4'd2,
    MOP_AND = 4'd3,
    MOP_OR  = 4'd4,
    MOP_XOR = 4'd5,
    MOP_SHL = 4'd6,
    MOP_SHR = 4'd7,
    MOP_LD  = 4'd8,
    MOP_ST  = 4'd9,
    MOP_BR  = 4'd10,
    MOP_JMP = 4'd11
  } mop_opcode_e;

  typedef struct packed {
    mop_opcode_e op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
  } micro_op_t;

  typedef micro_op_t mop_queue_lane_t;

  localparam int MOP_Q_DEPTH = 16;
  localparam int MOP_Q_ENQ_W = 4;
  localparam int MOP_Q_DEQ_W = 2;

endpackage
`default_nettype wire

// File: rtl/mop_queue_stats.sv
`default_nettype none
// ============================================================================
// Module      : mop_queue_stats
// Description : Occupancy high-water mark and enqueue-stall counter.
//   clk          in   clock
//   reset        in   synchronous active-high reset, clears both counters
//   i_count_next in   next-cycle occupancy of the queue
//   i_stall      in   enqueue group was refused this cycle
//   o_hwm        out  maximum i_count_next seen since reset
//   o_stall_cnt  out  saturating count of refused-enqueue cycles
// Revision    : 1.0 - initial release
// ============================================================================
module mop_queue_stats #(
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CNT_W-1:0] i_count_next,
  input  logic             i_stall,
  output logic [CNT_W-1:0] o_hwm,
  output logic [31:0]      o_stall_cnt
);

  logic [CNT_W-1:0] r_hwm;
  logic [31:0]      r_stall_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_hwm       <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (i_count_next > r_hwm) begin
        r_hwm <= i_count_next;
      end
      // Saturate rather than wrap so a long stall storm stays visible.
      if (i_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
        r_stall_cnt <= r_stall_cnt + 32'd1;
      end
    end
  end

  assign o_hwm       = r_hwm;
  assign o_stall_cnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: rtl/micro_op_queue.sv
`default_nettype none
// ============================================================================
// Module      : micro_op_queue
// Description : Multi-lane in-order FIFO of micro-ops between decoder and
//               register-read. Accepts up to ENQ_W micro-ops per cycle as an
//               all-or-nothing group, presents up to DEQ_W oldest entries.
//   clk, reset   clock / synchronous active-high reset
//   flush        drop all contents (redirect)
//   enq_count    valid lanes in enq_mop (lane 0 oldest)
//   enq_mop      ENQ_W packed micro-ops
//   enq_ready    group of enq_count fits in the current free space
//   deq_valid    thermometer-coded valid lanes from lane 0
//   deq_mop      DEQ_W oldest micro-ops, zero in invalid lanes
//   deq_take     lanes consumed this cycle (clamped to visible)
//   occupancy    current entry count
//   stat_hwm     occupancy high-water mark
//   stat_stall   cycles in which enqueue was refused
// Build option: MOP_QUEUE_STATS_EN enables the statistics counters; when
//               undefined stat_hwm/stat_stall read as zero.
// Revision    : 1.0 - initial release
// ============================================================================
module micro_op_queue
  import micro_op_queue_pkg::*;
#(
  parameter int DEPTH = MOP_Q_DEPTH,
  parameter int ENQ_W = MOP_Q_ENQ_W,
  parameter int DEQ_W = MOP_Q_DEQ_W
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               flush,
  input  logic [$clog2(ENQ_W+1)-1:0]         enq_count,
  input  logic [ENQ_W*$bits(micro_op_t)-1:0] enq_mop,
  output logic                               enq_ready,
  output logic [DEQ_W-1:0]                   deq_valid,
  output logic [DEQ_W*$bits(micro_op_t)-1:0] deq_mop,
  input  logic [$clog2(DEQ_W+1)-1:0]         deq_take,
  output logic [$clog2(DEPTH+1)-1:0]         occupancy,
  output logic [$clog2(DEPTH+1)-1:0]         stat_hwm,
  output logic [31:0]                        stat_stall
);

  localparam int c_PTR_W = $clog2(DEPTH);
  localparam int c_CNT_W = $clog2(DEPTH+1);
  localparam int c_MOP_W = $bits(micro_op_t);

  mop_queue_lane_t    r_mem [DEPTH];
  logic [c_PTR_W-1:0] r_head;
  logic [c_PTR_W-1:0] r_tail;
  logic [c_CNT_W-1:0] r_count;

  logic [c_CNT_W-1:0] w_free;
  logic [c_CNT_W-1:0] w_enq_n;
  logic [c_CNT_W-1:0] w_acc;
  logic [c_CNT_W-1:0] w_visible;
  logic [c_CNT_W-1:0] w_take_req;
  logic [c_CNT_W-1:0] w_take;
  logic [c_CNT_W-1:0] w_count_next;
  logic               w_accept;

  // Free space deliberately ignores same-cycle dequeues so enq_ready has no
  // path from deq_take.
  always_comb begin
    w_free       = c_CNT_W'(DEPTH) - r_count;
    w_enq_n      = c_CNT_W'(enq_count);
    enq_ready    = (w_enq_n <= w_free);
    w_accept     = enq_ready && (w_enq_n != '0) && !flush && !reset;
    w_acc        = w_accept ? w_enq_n : '0;
    w_visible    = (r_count < c_CNT_W'(DEQ_W)) ? r_count : c_CNT_W'(DEQ_W);
    w_take_req   = c_CNT_W'(deq_take);
    w_take       = (w_take_req < w_visible) ? w_take_req : w_visible;
    w_count_next = (reset || flush) ? '0 : (r_count + w_acc - w_take);
  end

  // Pointers wrap by natural overflow since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + c_PTR_W'(w_take);
      r_tail  <= r_tail + c_PTR_W'(w_acc);
      r_count <= w_count_next;
    end
  end

  // Storage is never cleared; stale entries are masked by deq_valid.
  always_ff @(posedge clk) begin
    for (int i = 0; i < ENQ_W; i++) begin
      if (w_accept && (c_CNT_W'(i) < w_enq_n)) begin
        r_mem[r_tail + c_PTR_W'(i)] <= enq_mop[i*c_MOP_W +: c_MOP_W];
      end
    end
  end

  always_comb begin
    deq_valid = '0;
    deq_mop   = '0;
    for (int i = 0; i < DEQ_W; i++) begin
      if (c_CNT_W'(i) < w_visible) begin
        deq_valid[i]                   = 1'b1;
        deq_mop[i*c_MOP_W +: c_MOP_W]  = r_mem[r_head + c_PTR_W'(i)];
      end
    end
  end

  assign occupancy = r_count;

`ifdef MOP_QUEUE_STATS_EN
  logic w_stall;
  assign w_stall = (enq_count != '0) && !enq_ready;

  mop_queue_stats #(
    .CNT_W (c_CNT_W)
  ) u_stats (
    .clk          (clk),
    .reset        (reset),
    .i_count_next (w_count_next),
    .i_stall      (w_stall),
    .o_hwm        (stat_hwm),
    .o_stall_cnt  (stat_stall)
  );
`else
  assign stat_hwm   = '0;
  assign stat_stall = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_micro_op_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_micro_op_queue
// Description : Self-checking bench for micro_op_queue. A queue-based model
//               tracks contents and statistics; each cycle the DUT outputs
//               are compared with the model before the clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_micro_op_queue;
  import micro_op_queue_pkg::*;

  localparam int DEPTH = 16;
  localparam int ENQ_W = 4;
  localparam int DEQ_W = 2;
  localparam int MW    = $bits(micro_op_t);
  localparam int CW    = $clog2(DEPTH+1);

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  flush;
  logic [2:0]            enq_count;
  logic [ENQ_W*MW-1:0]   enq_mop;
  logic                  enq_ready;
  logic [DEQ_W-1:0]      deq_valid;
  logic [DEQ_W*MW-1:0]   deq_mop;
  logic [1:0]            deq_take;
  logic [CW-1:0]         occupancy;
  logic [CW-1:0]         stat_hwm;
  logic [31:0]           stat_stall;

  always #5 clk = ~clk;

  micro_op_queue #(.DEPTH(DEPTH), .ENQ_W(ENQ_W), .DEQ_W(DEQ_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .enq_count  (enq_count),
    .enq_mop    (enq_mop),
    .enq_ready  (enq_ready),
    .deq_valid  (deq_valid),
    .deq_mop    (deq_mop),
    .deq_take   (deq_take),
    .occupancy  (occupancy),
    .stat_hwm   (stat_hwm),
    .stat_stall (stat_stall)
  );

  int total = 0;
  int bad   = 0;

  logic [MW-1:0] q[$];
  int            m_hwm   = 0;
  longint        m_stall = 0;
  bit            m_known = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < ENQ_W; i++) enq_mop[i*MW +: MW] = MW'($urandom);
  endtask

  // One clock cycle: drive, compare at the falling edge, advance the model.
  task automatic step(input int ec, input int dt, input bit fl, input bit rs);
    int            vis;
    int            tk;
    bit            rdy;
    logic [MW-1:0] exp_lane;
    logic [MW-1:0] lanes[ENQ_W];
    enq_count = 3'(ec);
    deq_take  = 2'(dt);
    flush     = fl;
    reset     = rs;
    @(negedge clk);
    vis = (q.size() < DEQ_W) ? q.size() : DEQ_W;
    rdy = (ec <= DEPTH - q.size());
    if (m_known) begin
      check("enq_ready", 64'(enq_ready), 64'(rdy));
      check("occupancy", 64'(occupancy), 64'(q.size()));
      for (int i = 0; i < DEQ_W; i++) begin
        check($sformatf("deq_valid[%0d]", i), 64'(deq_valid[i]), 64'(i < vis));
        exp_lane = '0;
        if (i < vis) exp_lane = q[i];
        check($sformatf("deq_mop[%0d]", i), 64'(deq_mop[i*MW +: MW]), 64'(exp_lane));
      end
`ifdef MOP_QUEUE_STATS_EN
      check("stat_hwm", 64'(stat_hwm), 64'(m_hwm));
      check("stat_stall", 64'(stat_stall), 64'(m_stall));
`else
      check("stat_hwm", 64'(stat_hwm), 64'd0);
      check("stat_stall", 64'(stat_stall), 64'd0);
`endif
    end
    for (int i = 0; i < ENQ_W; i++) lanes[i] = enq_mop[i*MW +: MW];
    if (rs) begin
      q.delete();
      m_hwm   = 0;
      m_stall = 0;
      m_known = 1'b1;
    end else begin
      if (ec > 0 && !rdy && m_stall < 64'hFFFF_FFFF) m_stall++;
      if (fl) begin
        q.delete();
      end else begin
        tk = (dt < vis) ? dt : vis;
        for (int k = 0; k < tk; k++) void'(q.pop_front());
        if (rdy) for (int k = 0; k < ec; k++) q.push_back(lanes[k]);
      end
      if (q.size() > m_hwm) m_hwm = q.size();
    end
    @(posedge clk);
    #1;
  endtask

  micro_op_t m_add, m_ld, m_st, m_br;

  initial begin
    reset = 1'b1; flush = 1'b0; enq_count = '0; deq_take = '0; enq_mop = '0;
    m_add = '{op: MOP_ADD, rd: 5'd1, rs1: 5'd2, rs2: 5'd3, imm: 13'd0};
    m_ld  = '{op: MOP_LD,  rd: 5'd4, rs1: 5'd5, rs2: 5'd0, imm: 13'd16};
    m_st  = '{op: MOP_ST,  rd: 5'd0, rs1: 5'd6, rs2: 5'd4, imm: 13'd8};
    m_br  = '{op: MOP_BR,  rd: 5'd0, rs1: 5'd7, rs2: 5'd8, imm: 13'h1ff0};
    @(posedge clk); #1;

    // Reset, then idle.
    step(0, 0, 0, 1); step(0, 0, 0, 1);
    step(0, 0, 0, 0); step(0, 2, 0, 0);

    // Three-op group, then take two.
    enq_mop = '0;
    enq_mop[0*MW +: MW] = m_add;
    enq_mop[1*MW +: MW] = m_ld;
    enq_mop[2*MW +: MW] = m_st;
    step(3, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 2, 0, 0);
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);

    // Fill to 14, then a 3-group that does not fit while taking 2.
    rand_lanes(); step(4, 0, 0, 0);
    rand_lanes(); step(4, 0, 0, 0);
    rand_lanes(); step(4, 0, 0, 0);
    rand_lanes(); step(2, 0, 0, 0);
    rand_lanes(); step(3, 2, 0, 0);
    step(0, 0, 0, 0);

    // Wrap: move both pointers to 14, then a 4-group across the boundary.
    step(0, 0, 0, 1);
    for (int k = 0; k < 3; k++) begin rand_lanes(); step(4, 0, 0, 0); end
    rand_lanes(); step(2, 0, 0, 0);
    for (int k = 0; k < 7; k++) step(0, 2, 0, 0);
    enq_mop[0*MW +: MW] = m_add;
    enq_mop[1*MW +: MW] = m_ld;
    enq_mop[2*MW +: MW] = m_st;
    enq_mop[3*MW +: MW] = m_br;
    step(4, 0, 0, 0);
    step(0, 2, 0, 0);
    step(0, 2, 0, 0);
    step(0, 0, 0, 0);

    // Flush at count 9 with competing enqueue and take.
    step(0, 0, 0, 1);
    rand_lanes(); step(4, 0, 0, 0);
    rand_lanes(); step(4, 0, 0, 0);
    rand_lanes(); step(1, 0, 0, 0);
    rand_lanes(); step(4, 2, 1, 0);
    step(0, 0, 0, 0);

    // Over-request with a single entry is clamped.
    rand_lanes(); step(1, 0, 0, 0);
    step(0, 2, 0, 0);
    step(0, 2, 0, 0);
    rand_lanes(); step(2, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 2, 0, 0);

    // Randomized traffic with occasional flush and reset.
    for (int n = 0; n < 600; n++) begin
      rand_lanes();
      step($urandom_range(0, 4), $urandom_range(0, 2),
           ($urandom_range(0, 24) == 0), ($urandom_range(0, 149) == 0));
    end
    step(0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/micro_op_queue.md
# micro_op_queue

Parametrised multi-lane FIFO that buffers `micro_op_t` entries between the instruction decoder and the register-read stage. The decoder cracks one `fat_instruction_t` into a variable number of micro-ops. This queue accepts up to ENQ_W of them per cycle as an all-or-nothing group and presents up to DEQ_W of them per cycle, in order, to the back end. A flush input empties the queue on a redirect, for example when a jump resolves.

## Interface
Parameters:
- DEPTH, 16, entry count; power of two; DEPTH ≥ ENQ_W and DEPTH ≥ DEQ_W
- ENQ_W, 4, maximum micro-ops enqueued per cycle
- DEQ_W, 2, maximum micro-ops presented and taken per cycle

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all contents this cycle
- enq_count  in  $clog2(ENQ_W+1)  number of valid lanes in enq_mop; lanes 0..enq_count-1
- enq_mop  in  ENQ_W×$bits(micro_op_t)  micro-ops; lane 0 is oldest
- enq_ready  out  1  group of enq_count fits; 1 when enq_count = 0
- deq_valid  out  DEQ_W  lane i holds a valid micro-op; thermometer coded from lane 0
- deq_mop  out  DEQ_W×$bits(micro_op_t)  oldest micro-ops; lane 0 is head
- deq_take  in  $clog2(DEQ_W+1)  number of lanes the consumer takes this cycle
- occupancy  out  $clog2(DEPTH+1)  current entry count
- stat_hwm  out  $clog2(DEPTH+1)  occupancy high-water mark
- stat_stall  out  32  cycles in which enqueue was refused

## Operation
- State: storage array[DEPTH], head and tail pointers (log2 DEPTH bits), count (log2 DEPTH + 1 bits).
  - Pointers wrap modulo DEPTH by natural overflow.
- Free slots: free = DEPTH − count, computed from registered count only.
- Enqueue rules:
  - enq_ready = (enq_count ≤ free).
  - When enq_ready and enq_count > 0, lanes 0..enq_count-1 are written at tail, tail+1, … and tail advances by enq_count.
  - Acceptance is all-or-nothing. No partial groups are ever accepted.
  - Slots freed by a same-cycle dequeue do NOT count toward free.
- Dequeue rules:
  - visible = min(count, DEQ_W).
  - deq_valid[i] = (i < visible).
  - deq_mop[i] = storage[head+i] when valid, else all-zero.
  - Effective take = min(deq_take, visible); an over-request is clamped, never underflows.
  - head advances by the effective take.
- Count update: count_next = count + accepted_enq − effective_take. Both may occur in the same cycle.
- Flush:
  - Priority over enqueue and dequeue.
  - head = tail = count = 0.
  - Enqueue and take in that cycle are ignored.
  - Storage is not cleared.
- Reset: same state effect as flush.
  - Reset takes priority over flush.
  - Reset also clears statistics.

## Timing
- Output reset values:
  - enq_ready = 1 when enq_count ≤ DEPTH; always 1 with the default parameters.
  - deq_valid = 0, deq_mop = 0, occupancy = 0, stat_hwm = 0, stat_stall = 0.
- Enqueue-to-visible latency is 1 cycle. An entry written in cycle N appears on deq_mop in cycle N+1.
  - There is no combinational path from enq_* to deq_*.
- enq_ready is combinational from enq_count and registered count.
- deq_valid, deq_mop and occupancy are functions of registered state only.
- Full boundary: at count = DEPTH, enq_ready = 0 for any enq_count > 0, even if deq_take > 0 in the same cycle.
- Empty boundary: at count = 0, deq_valid = 0 and deq_take is ignored.
- Wrap-around: groups and dequeue windows spanning index DEPTH-1 → 0 must be handled within a single cycle.

## Configuration
- MOP_QUEUE_STATS_EN defined:
  - stat_hwm registers the maximum count_next since reset. Flush does not clear it.
  - stat_stall increments each cycle with enq_count > 0 and enq_ready = 0, saturating at 2^32−1. It is not counted during reset.
- MOP_QUEUE_STATS_EN undefined:
  - stat_hwm and stat_stall are tied to 0 and no statistics flops exist.
  - The port list is identical in both builds.

## Structure
- The `DecoderTypes` package carries two additions:
  - `mop_queue_lane_t`, an alias of `micro_op_t` used for lane arrays.
  - Default localparams MOP_Q_DEPTH = 16, MOP_Q_ENQ_W = 4, MOP_Q_DEQ_W = 2, so decoder and back end agree on widths.
- One sub-module, `mop_queue_stats`, holds the high-water and stall counters. It is instantiated only under MOP_QUEUE_STATS_EN.
- Pointer/lane arithmetic stays in micro_op_queue.

## Test plan
- Reset, then idle → occupancy = 0, deq_valid = 2'b00, enq_ready = 1, deq_mop = 0.
- Enqueue 3 micro-ops (m_add, m_ld, m_st) in cycle N, deq_take = 0 →
  - cycle N+1: deq_valid = 2'b11, lane 0 = m_add, lane 1 = m_ld, occupancy = 3.
  - After deq_take = 2: deq_valid = 2'b01, lane 0 = m_st.
- Fill to count = 14, then present enq_count = 3 with deq_take = 2 →
  - enq_ready = 0, nothing written, occupancy becomes 12.
  - stat_stall increments by 1 when MOP_QUEUE_STATS_EN is defined.
- Wrap-around:
  - Advance head/tail to 14, then enqueue 4 micro-ops → they land in slots 14, 15, 0, 1.
  - Dequeue 2 per cycle until empty → original order preserved.
- Flush with count = 9, enq_count = 4 and deq_take = 2 in the same cycle →
  - next cycle occupancy = 0, deq_valid = 0.
  - stat_hwm stays 9 (or 0 when the macro is undefined).
- With count = 1, deq_take = 2 → clamped take of 1, occupancy = 0, no underflow, pointers stay consistent.
